// File: rtl/div_pkg.sv
// Purpose: shared types and default sizing for the round-robin divider scheduler.
// Ports: none (package).
package div_pkg;

    localparam int unsigned DEF_WIDTH = 6;
    localparam int unsigned DEF_NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_rr_arbiter.sv
// Purpose: combinational round-robin grant, searching upward from rr_ptr with wrap.
// Ports:
//   i_req_valid  in   NREQ   per-requester valid
//   i_rr_ptr     in   ID_W   highest-priority requester index
//   o_gnt_vld    out  1      some requester is granted
//   o_gnt_id     out  ID_W   granted requester index
module div_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = 1
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [ID_W-1:0] i_rr_ptr,
    output logic            o_gnt_vld,
    output logic [ID_W-1:0] o_gnt_id
);

    // Walk offsets from the far end down so the nearest valid requester wins last.
    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_id  = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            int unsigned j;
            j = int'(i_rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (i_req_valid[j]) begin
                o_gnt_vld = 1'b1;
                o_gnt_id  = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/div_sub.sv
// Purpose: shared compare/subtract datapath; borrow set means b > a.
// Ports:
//   i_a       in   W   minuend (partial remainder)
//   i_b       in   W   subtrahend (shifted divisor)
//   o_diff    out  W   a - b
//   o_borrow  out  1   a < b
module div_sub #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/div_rr_sched.sv
// Purpose: round-robin scheduler sharing one restoring divider between NREQ requesters.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req_valid  in   NREQ        per-requester request valid
//   req_ready  out  NREQ        one-hot accept strobe (IDLE only)
//   req_a/b    in   NREQ*WIDTH  packed dividends / divisors
//   rsp_valid  out  1           response valid
//   rsp_ready  in   1           response consumer ready
//   rsp_id     out  ID_W        requester being answered
//   rsp_q/r    out  WIDTH       quotient / remainder
//   rsp_dbz    out  1           divide-by-zero flag
module div_rr_sched
    import div_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned NREQ  = DEF_NREQ,
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_q,
    output logic [WIDTH-1:0]      rsp_r,
    output logic                  rsp_dbz
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            r_state, w_state_n;
    logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_n;
    logic [W2-1:0]     r_ra, w_ra_n;
    logic [W2-1:0]     r_rb, w_rb_n;
    logic [WIDTH-1:0]  r_q, w_q_n;
    logic [IDX_W-1:0]  r_idx, w_idx_n;
    logic [ID_W-1:0]   r_id, w_id_n;
    logic              r_dbz, w_dbz_n;
    logic              r_rsp_valid, w_rsp_valid_n;
    logic [ID_W-1:0]   r_rsp_id, w_rsp_id_n;
    logic [WIDTH-1:0]  r_rsp_q, w_rsp_q_n;
    logic [WIDTH-1:0]  r_rsp_r, w_rsp_r_n;
    logic              r_rsp_dbz, w_rsp_dbz_n;

    logic              w_gnt_vld;
    logic [ID_W-1:0]   w_gnt_id;
    logic [WIDTH-1:0]  w_a, w_b;
    logic [W2-1:0]     w_temp, w_diff;
    logic              w_borrow;

    div_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_gnt_vld   (w_gnt_vld),
        .o_gnt_id    (w_gnt_id)
    );

    // Divisor aligned to the quotient bit under test.
    assign w_temp = r_rb << r_idx;

    div_sub #(
        .W (W2)
    ) u_sub (
        .i_a      (r_ra),
        .i_b      (w_temp),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // Operand mux for the granted requester.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_n     = r_state;
        w_rr_ptr_n    = r_rr_ptr;
        w_ra_n        = r_ra;
        w_rb_n        = r_rb;
        w_q_n         = r_q;
        w_idx_n       = r_idx;
        w_id_n        = r_id;
        w_dbz_n       = r_dbz;
        w_rsp_valid_n = r_rsp_valid;
        w_rsp_id_n    = r_rsp_id;
        w_rsp_q_n     = r_rsp_q;
        w_rsp_r_n     = r_rsp_r;
        w_rsp_dbz_n   = r_rsp_dbz;
        req_ready     = '0;

        case (r_state)
            IDLE: begin
                if (w_gnt_vld && !rst) begin
                    req_ready = NREQ'(1) << w_gnt_id;
                    w_ra_n    = {{WIDTH{1'b0}}, w_a};
                    w_rb_n    = {{WIDTH{1'b0}}, w_b};
                    w_id_n    = w_gnt_id;
                    w_idx_n   = IDX_W'(WIDTH - 1);
                    if (w_b == '0) begin
                        // Remainder already holds a, which is the dbz result.
                        w_q_n     = '1;
                        w_dbz_n   = 1'b1;
                        w_state_n = DONE;
                    end else begin
                        w_q_n     = '0;
                        w_dbz_n   = 1'b0;
                        w_state_n = CALC;
                    end
                end
            end
            CALC: begin
                if (!w_borrow) begin
                    w_ra_n = w_diff;
                end
                // MSB-first: shift each new quotient bit in from the right.
                w_q_n = WIDTH'({r_q, ~w_borrow});
                if (r_idx == '0) begin
                    w_state_n = DONE;
                end else begin
                    w_idx_n = r_idx - 1'b1;
                end
            end
            DONE: begin
                if (!r_rsp_valid) begin
                    w_rsp_valid_n = 1'b1;
                    w_rsp_id_n    = r_id;
                    w_rsp_q_n     = r_q;
                    w_rsp_r_n     = r_ra[WIDTH-1:0];
                    w_rsp_dbz_n   = r_dbz;
                end else if (rsp_ready) begin
                    w_rsp_valid_n = 1'b0;
                    w_rr_ptr_n    = (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;
                    w_state_n     = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_q         <= '0;
            r_idx       <= '0;
            r_id        <= '0;
            r_dbz       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_dbz   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_rr_ptr    <= w_rr_ptr_n;
            r_ra        <= w_ra_n;
            r_rb        <= w_rb_n;
            r_q         <= w_q_n;
            r_idx       <= w_idx_n;
            r_id        <= w_id_n;
            r_dbz       <= w_dbz_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_id    <= w_rsp_id_n;
            r_rsp_q     <= w_rsp_q_n;
            r_rsp_r     <= w_rsp_r_n;
            r_rsp_dbz   <= w_rsp_dbz_n;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_q     = r_rsp_q;
    assign rsp_r     = r_rsp_r;
    assign rsp_dbz   = r_rsp_dbz;

endmodule
